// File: rtl/tdc_calsched.sv
// Calibration sequencer for the SERDES TDC channel.
// On a CSR start it routes the ring-oscillator test clock into the TDC,
// waits a settle time, arms the TDC for NEVENTS hits (bounded by TIMEOUT),
// then drains for a fixed number of cycles before restoring the normal path
// and raising done plus a one-cycle irq.
module tdc_calsched #(
  parameter logic [3:0]  csr_addr        = 4'h2,
  parameter logic [15:0] settle_default  = 16'd1000,
  parameter logic [15:0] nevents_default = 16'd256,
  parameter logic [23:0] timeout_default = 24'hFFFFFF,
  parameter int          drain_cycles    = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        tdc_event,
  output logic        osc_en,
  output logic        sel_calib,
  output logic        tdc_arm,
  output logic        irq
);

  localparam int            DW         = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(drain_cycles - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACQ, DRAIN} state_t;

  // Decoded CSR access for this cycle.
  typedef struct packed {
    logic       sel;
    logic       wr;
    logic [2:0] idx;
    logic       start;
    logic       abort;
    logic       clear;
  } csr_req_t;

  csr_req_t      req;
  state_t        state, state_nxt;

  logic [15:0]   settle_reg, nevents_reg;
  logic [23:0]   timeout_reg;

  logic [15:0]   settle_cnt;
  logic [15:0]   nev_w;
  logic [23:0]   tmo_cnt;
  logic [15:0]   count, count_nxt;
  logic [DW-1:0] drain_cnt;

  logic          done, err, busy;
  logic          load, drain_err, finish, enter_drain;
  logic          ev_hit, tmo_hit;

  logic          unused_bits;
  assign unused_bits = ^{csr_a[9:3], csr_di[31:24]};

  // CSR decode: only CTRL writes generate command strobes; abort beats start.
  always_comb begin
    req       = '0;
    req.sel   = (csr_a[13:10] == csr_addr);
    req.idx   = csr_a[2:0];
    req.wr    = (csr_a[13:10] == csr_addr) && csr_we;
    req.start = req.wr && (csr_a[2:0] == 3'd0) && csr_di[0] && !csr_di[1];
    req.abort = req.wr && (csr_a[2:0] == 3'd0) && csr_di[1];
    req.clear = req.wr && (csr_a[2:0] == 3'd0) && csr_di[2];
  end

  assign busy = (state != IDLE);

  // Event counting only happens while armed; the completion compare sees this cycle's hit.
  assign count_nxt = (state == ACQ && tdc_event && count != 16'hFFFF) ? count + 16'd1 : count;
  assign ev_hit    = (count_nxt >= nev_w);
  assign tmo_hit   = (tmo_cnt <= 24'd1);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drain_err = 1'b0;
    finish    = 1'b0;
    osc_en    = 1'b0;
    sel_calib = 1'b0;
    tdc_arm   = 1'b0;
    case (state)
      IDLE: begin
        if (req.start) begin
          state_nxt = SETTLE;
          load      = 1'b1;
        end
      end
      SETTLE: begin
        sel_calib = 1'b1;
        osc_en    = 1'b1;
        if (req.abort) begin
          state_nxt = DRAIN;
          drain_err = 1'b1;
        end else if (settle_cnt == 16'd0) begin
          state_nxt = ACQ;
        end
      end
      ACQ: begin
        sel_calib = 1'b1;
        osc_en    = 1'b1;
        tdc_arm   = 1'b1;
        if (req.abort) begin
          state_nxt = DRAIN;
          drain_err = 1'b1;
        end else if (ev_hit) begin
          // final hit beats a coincident timeout
          state_nxt = DRAIN;
        end else if (tmo_hit) begin
          state_nxt = DRAIN;
          drain_err = 1'b1;
        end
      end
      DRAIN: begin
        sel_calib = 1'b1;
        if (drain_cnt == '0) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_drain = (state != DRAIN) && (state_nxt == DRAIN);

  // Programmable configuration; busy-time writes only touch these shadows.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      settle_reg  <= settle_default;
      nevents_reg <= nevents_default;
      timeout_reg <= timeout_default;
    end else if (req.wr) begin
      case (req.idx)
        3'd1:    settle_reg  <= csr_di[15:0];
        3'd2:    nevents_reg <= csr_di[15:0];
        3'd3:    timeout_reg <= csr_di[23:0];
        default: ;
      endcase
    end
  end

  // Working counters, loaded at start so the running sequence is insulated from CSR writes.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      settle_cnt <= '0;
      nev_w      <= '0;
      tmo_cnt    <= '0;
      count      <= '0;
      drain_cnt  <= '0;
    end else begin
      if (load) begin
        settle_cnt <= settle_reg;
        nev_w      <= nevents_reg;
        tmo_cnt    <= timeout_reg;
        count      <= '0;
      end else begin
        if (state == SETTLE && settle_cnt != 16'd0) settle_cnt <= settle_cnt - 16'd1;
        if (state == ACQ && tmo_cnt != 24'd0)       tmo_cnt    <= tmo_cnt - 24'd1;
        count <= count_nxt;
      end
      if (enter_drain)                           drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Sticky status and completion pulse; completion and error entry override a clear.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      irq <= finish;
      if (load) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (req.clear && !finish) begin
          done <= 1'b0;
          err  <= 1'b0;
        end
        if (drain_err) err  <= 1'b1;
        if (finish)    done <= 1'b1;
      end
    end
  end

  // Registered read port; zero when another page is addressed.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
    end else if (req.sel) begin
      case (req.idx)
        3'd0:    csr_do <= {28'd0, err, done, busy, busy};
        3'd1:    csr_do <= {16'd0, settle_reg};
        3'd2:    csr_do <= {16'd0, nevents_reg};
        3'd3:    csr_do <= {8'd0, timeout_reg};
        3'd4:    csr_do <= {16'd0, count};
        default: csr_do <= '0;
      endcase
    end else begin
      csr_do <= '0;
    end
  end

endmodule
